// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - sequential AES-128/256 key schedule streaming round keys
module aes_key_schedule_seq #(
  parameter int SUPPORT_256 = 1,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key_len,
  input  logic [255:0]     key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             done
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the slice base is (255 - x) * 8.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_len;
  logic [127:0]     r_a;
  logic [127:0]     r_b;
  logic [127:0]     r_out;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_rcon;

  logic             w_len_in;
  logic             w_accept;
  logic             w_hs;
  logic             w_last;
  logic             w_use_rcon;
  logic [31:0]      w_rot;
  logic [31:0]      w_t;
  logic [31:0]      w_w0;
  logic [31:0]      w_w1;
  logic [31:0]      w_w2;
  logic [31:0]      w_w3;
  logic [127:0]     w_new;
  logic [7:0]       w_rcon_nxt;

  assign w_len_in = (SUPPORT_256 != 0) && key_len;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_hs     = (r_state == S_RUN) && rk_ready;
  assign w_last   = (r_idx == (r_len ? IDX_W'(14) : IDX_W'(10)));

  // The key being generated is index r_idx+1; in AES-256 only even indices rotate and take Rcon.
  assign w_use_rcon = !r_len || r_idx[0];
  assign w_rot      = {r_b[23:0], r_b[31:24]};
  assign w_t        = sub_word(w_use_rcon ? w_rot : r_b[31:0])
                    ^ {(w_use_rcon ? r_rcon : 8'h00), 24'h0};
  assign w_w0       = r_a[127:96] ^ w_t;
  assign w_w1       = r_a[95:64] ^ w_w0;
  assign w_w2       = r_a[63:32] ^ w_w1;
  assign w_w3       = r_a[31:0] ^ w_w2;
  assign w_new      = {w_w0, w_w1, w_w2, w_w3};
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_hs && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_out  <= '0;
      r_idx  <= '0;
      r_rcon <= 8'h01;
    end else if (w_accept) begin
      r_len  <= w_len_in;
      r_a    <= key_in[255:128];
      r_b    <= w_len_in ? key_in[127:0] : key_in[255:128];
      r_out  <= key_in[255:128];
      r_idx  <= '0;
      r_rcon <= 8'h01;
    end else if (w_hs && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
      // AES-256 rk1 is the low key half, already held in B.
      if (r_len && (r_idx == '0)) begin
        r_out <= r_b;
      end else begin
        r_out <= w_new;
        r_a   <= r_len ? r_b : w_new;
        r_b   <= w_new;
        if (w_use_rcon) r_rcon <= w_rcon_nxt;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign rk_valid = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign rk_out   = r_out;
  assign rk_idx   = r_idx;

endmodule
